onchip_ram_avmm_pipelined: RTL and testbench

Parametrised single-port on-chip RAM presented as an Avalon-MM slave to the Nios II system interconnect. It extends the fixed 1024x32 unregistered-output memory with:
- configurable width, depth and read latency
- pipelined reads with `readdatavalid`
- `waitrequest` back-pressure
- an optional post-reset zero-fill (clear) sequencer

It replaces the fixed memory in new system builds.

---
 rtl/onchip_ram_pkg.sv | 18 +
 rtl/onchip_ram_core.sv | 29 ++
 rtl/onchip_ram_avmm_pipelined.sv | 146 ++++++++++++++
 tb/tb_onchip_ram_avmm_pipelined.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ram_pkg.sv
// Shared types and constants for the Avalon-MM on-chip RAM.
package onchip_ram_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    CLEAR = 2'd1,
    READY = 2'd2
  } ram_state_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

  // Number of words addressed by an addr_w-bit word address.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Inferred single-port RAM: byte-lane write, registered (synchronous) read.
module onchip_ram_core
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic [DATA_W/8-1:0] we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   q
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes and the read register share one address port.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (re) q <= mem[addr];
  end

endmodule

// File: rtl/onchip_ram_avmm_pipelined.sv
// Avalon-MM slave wrapper around onchip_ram_core: zero-fill sequencer,
// request acceptance, and a read-valid/data pipeline of 1 or 2 stages.
module onchip_ram_avmm_pipelined
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int READ_LATENCY   = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic                reset_req,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  if (READ_LATENCY < LAT_MIN || READ_LATENCY > LAT_MAX) begin : g_bad_latency
    $error("onchip_ram_avmm_pipelined: READ_LATENCY must be 1 or 2");
  end
  if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_width
    $error("onchip_ram_avmm_pipelined: DATA_W must be a non-zero multiple of 8");
  end
  if (ADDR_W < 1) begin : g_bad_addr
    $error("onchip_ram_avmm_pipelined: ADDR_W must be at least 1");
  end
  if (CLEAR_ON_RESET != 0 && CLEAR_ON_RESET != 1) begin : g_bad_clear
    $error("onchip_ram_avmm_pipelined: CLEAR_ON_RESET must be 0 or 1");
  end

  ram_state_e        state;
  logic [ADDR_W-1:0] clear_addr;
  logic              en;
  logic              ready;
  logic              clr_wr;
  logic              wr_acc;
  logic              rd_acc;
  logic [BE_W-1:0]   ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;
  logic              vld_p0;
  logic              vld_p1;
  logic              vld_p2;
  logic [DATA_W-1:0] rdata_p1;
  logic [DATA_W-1:0] rdata_p2;
  logic              vld_out;

  // reset_req protects the array exactly like a dropped clock enable.
  assign en          = clken & ~reset_req;
  assign ready       = en & reset_n & (state == READY);
  assign waitrequest = ~ready;
  assign wr_acc      = chipselect & write & ready;
  // A simultaneous write wins; the read is discarded without a valid.
  assign rd_acc      = chipselect & read & ~write & ready;
  assign clr_wr      = en & reset_n & (state == CLEAR);

  // The zero-fill sequencer owns the RAM port while clearing.
  always_comb begin
    ram_addr  = address;
    ram_wdata = writedata;
    ram_we    = '0;
    if (clr_wr) begin
      ram_addr  = clear_addr;
      ram_wdata = '0;
      ram_we    = '1;
    end else if (wr_acc) begin
      ram_we = byteenable;
    end
  end

  onchip_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (ram_we),
    .re    (rd_acc),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // Control FSM and clear address counter; a reset restarts clearing at 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= RESET;
      clear_addr <= '0;
    end else if (en) begin
      unique case (state)
        RESET:   state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
        CLEAR: begin
          clear_addr <= clear_addr + 1'b1;
          if (clear_addr == LAST_ADDR) state <= READY;
        end
        READY:   state <= READY;
        default: state <= RESET;
      endcase
    end
  end

  // Stage p0: accept edge; the core registers the addressed word.
  always_ff @(posedge clk) begin
    if (!reset_n) vld_p0 <= 1'b0;
    else if (en)  vld_p0 <= rd_acc;
  end

  // Stage p1: first output register, holds data between valid beats.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else if (en) begin
      vld_p1 <= vld_p0;
      if (vld_p0) rdata_p1 <= ram_q;
    end
  end

  // Stage p2: extra output register used when READ_LATENCY is 2.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p2   <= 1'b0;
      rdata_p2 <= '0;
    end else if (en) begin
      vld_p2 <= vld_p1;
      if (vld_p1) rdata_p2 <= rdata_p1;
    end
  end

  // A frozen valid is hidden, then shown again once enable returns.
  assign vld_out       = (READ_LATENCY == LAT_MAX) ? vld_p2 : vld_p1;
  assign readdata      = (READ_LATENCY == LAT_MAX) ? rdata_p2 : rdata_p1;
  assign readdatavalid = vld_out & en & reset_n;

endmodule

// File: tb/tb_onchip_ram_avmm_pipelined.sv
// Self-checking bench: u_dut0 (16 words, latency 2, clear on reset) is
// tracked cycle by cycle against a behavioural model; u_dut1 (latency 1,
// no clear) gets directed latency and freeze checks.
module tb_onchip_ram_avmm_pipelined;

  localparam int AW     = 4;
  localparam int DEPTH0 = 16;
  localparam int LAT0   = 2;

  typedef struct {
    int          rem;
    logic [31:0] data;
  } rd_item_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // u_dut0 stimulus/response
  logic          rst_n = 1'b0, clken = 1'b1, rreq = 1'b0;
  logic          cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [3:0]    be = '0;
  logic [31:0]   wd = '0;
  logic [31:0]   rdata;
  logic          rvalid, wreq;

  // u_dut1 stimulus/response
  logic          rst1_n = 1'b0, clken1 = 1'b1, rreq1 = 1'b0;
  logic          cs1 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [3:0]    be1 = '0;
  logic [31:0]   wd1 = '0;
  logic [31:0]   rdata1;
  logic          rvalid1, wreq1;

  onchip_ram_avmm_pipelined #(
    .DATA_W(32), .ADDR_W(AW), .READ_LATENCY(LAT0), .CLEAR_ON_RESET(1)
  ) u_dut0 (
    .clk(clk), .reset_n(rst_n), .clken(clken), .reset_req(rreq),
    .chipselect(cs), .read(rd), .write(wr), .address(addr),
    .byteenable(be), .writedata(wd), .readdata(rdata),
    .readdatavalid(rvalid), .waitrequest(wreq)
  );

  onchip_ram_avmm_pipelined #(
    .DATA_W(32), .ADDR_W(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(0)
  ) u_dut1 (
    .clk(clk), .reset_n(rst1_n), .clken(clken1), .reset_req(rreq1),
    .chipselect(cs1), .read(rd1), .write(wr1), .address(addr1),
    .byteenable(be1), .writedata(wd1), .readdata(rdata1),
    .readdatavalid(rvalid1), .waitrequest(wreq1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of u_dut0
  logic [31:0] ref_mem [DEPTH0];
  rd_item_t    q0[$];
  logic [31:0] m_last    = '0;
  bit          m_ready   = 1'b0;
  bit          m_pending = 1'b0;
  int          m_clr     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  // One clock: advance the model on the edge, then check u_dut0 outputs.
  task automatic tick();
    logic          en_e, rst_e, cs_e, rd_e, wr_e, en_now, exp_v, exp_w;
    logic [AW-1:0] a_e;
    logic [3:0]    be_e;
    logic [31:0]   wd_e;
    en_e = clken & ~rreq; rst_e = rst_n; cs_e = cs; rd_e = rd; wr_e = wr;
    a_e = addr; be_e = be; wd_e = wd;
    @(posedge clk);
    if (!rst_e) begin
      q0.delete();
      m_last = '0; m_ready = 1'b0; m_pending = 1'b1; m_clr = 0;
    end else if (en_e) begin
      if (q0.size() > 0 && q0[0].rem == 0) void'(q0.pop_front());
      foreach (q0[i]) q0[i].rem--;
      if (m_pending) begin
        m_pending = 1'b0;
        m_clr = DEPTH0;
      end else if (m_clr > 0) begin
        m_clr--;
        if (m_clr == 0) begin
          foreach (ref_mem[i]) ref_mem[i] = '0;
          m_ready = 1'b1;
        end
      end else if (m_ready && cs_e) begin
        if (wr_e) ref_mem[a_e] = merge(ref_mem[a_e], wd_e, be_e);
        else if (rd_e) q0.push_back(rd_item_t'{rem: LAT0, data: ref_mem[a_e]});
      end
      if (q0.size() > 0 && q0[0].rem == 0) m_last = q0[0].data;
    end
    #1;
    en_now = clken & ~rreq;
    exp_w  = ~(m_ready & en_now & rst_n);
    exp_v  = rst_n && en_now && q0.size() > 0 && q0[0].rem == 0;
    chk("waitrequest", {31'b0, wreq}, {31'b0, exp_w});
    chk("readdatavalid", {31'b0, rvalid}, {31'b0, exp_v});
    chk("readdata", rdata, m_last);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; wd = d; be = b;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_expect(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    tick();
    cs = 1'b0; rd = 1'b0;
    tick();
    tick();
    chk({tag, "_vld"}, {31'b0, rvalid}, 32'd1);
    chk(tag, rdata, exp);
  endtask

  task automatic count_clear(input string tag);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wreq === 1'b1) cnt++;
      else break;
    end
    chk(tag, cnt, DEPTH0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] da, db, dc, d1, d2;
    int op;

    // Reset values on both instances
    repeat (3) tick();
    chk("rst_wreq1", {31'b0, wreq1}, 32'd1);
    chk("rst_vld1", {31'b0, rvalid1}, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);

    // Clear after first reset, preload, reset, clear again
    rst_n = 1'b1;
    count_clear("clear_len");
    do_write(4'd5, 32'hDEADBEEF, 4'hF);
    rd_expect(4'd5, 32'hDEADBEEF, "preload");
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    count_clear("clear_len2");
    rd_expect(4'd5, 32'h0, "clear_zero");

    // Byte enables
    do_write(4'd3, 32'h11223344, 4'hF);
    do_write(4'd3, 32'hAABBCCDD, 4'b0101);
    rd_expect(4'd3, 32'h11BB33DD, "byte_en");

    // Back-to-back pipelined reads
    da = $urandom; db = $urandom; dc = $urandom;
    do_write(4'd0, da, 4'hF);
    do_write(4'd1, db, 4'hF);
    do_write(4'd2, dc, 4'hF);
    cs = 1'b1; rd = 1'b1; addr = 4'd0; tick();
    addr = 4'd1; tick();
    addr = 4'd2; tick();
    cs = 1'b0; rd = 1'b0;
    chk("pipe_a_vld", {31'b0, rvalid}, 32'd1); chk("pipe_a", rdata, da);
    tick();
    chk("pipe_b_vld", {31'b0, rvalid}, 32'd1); chk("pipe_b", rdata, db);
    tick();
    chk("pipe_c_vld", {31'b0, rvalid}, 32'd1); chk("pipe_c", rdata, dc);
    tick();
    chk("pipe_end", {31'b0, rvalid}, 32'd0);

    // Read and write together: write wins, no valid
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 4'd7; wd = 32'h5; be = 4'hF;
    tick();
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    tick(); tick();
    chk("conflict_novld", {31'b0, rvalid}, 32'd0);
    rd_expect(4'd7, 32'h5, "conflict_wr");

    // reset_req behaves as a dropped clock enable
    rreq = 1'b1; cs = 1'b1; rd = 1'b1; addr = 4'd7;
    tick();
    chk("rreq_wait", {31'b0, wreq}, 32'd1);
    tick();
    rreq = 1'b0; cs = 1'b0; rd = 1'b0;
    tick(); tick(); tick();

    // Reset with a read in flight
    cs = 1'b1; rd = 1'b1; addr = 4'd3; tick();
    cs = 1'b0; rd = 1'b0; rst_n = 1'b0;
    tick(); tick();
    chk("flush_novld", {31'b0, rvalid}, 32'd0);
    rst_n = 1'b1;
    count_clear("clear_len3");

    // Reset while the clear sequencer is at address 9
    do_write(4'd12, 32'hCAFEF00D, 4'hF);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (10) tick();
    chk("mid_clear_wait", {31'b0, wreq}, 32'd1);
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    count_clear("clear_restart");
    rd_expect(4'd12, 32'h0, "restart_zero");

    // Randomised traffic with enable freezes and reset_req pulses
    for (int i = 0; i < 80; i++) begin
      op    = int'($urandom_range(0, 3));
      cs    = ($urandom_range(0, 7) != 0);
      rd    = (op == 2 || op == 3);
      wr    = (op == 1 || op == 3);
      addr  = 4'($urandom_range(0, 15));
      wd    = $urandom;
      be    = 4'($urandom_range(0, 15));
      clken = ($urandom_range(0, 5) != 0);
      rreq  = ($urandom_range(0, 9) == 0);
      tick();
    end
    cs = 1'b0; rd = 1'b0; wr = 1'b0; clken = 1'b1; rreq = 1'b0;
    repeat (4) tick();

    // Latency-1 instance without clear
    rst1_n = 1'b1;
    tick();
    chk("noclr_ready", {31'b0, wreq1}, 32'd0);
    d1 = $urandom;
    cs1 = 1'b1; wr1 = 1'b1; addr1 = 4'd2; wd1 = d1; be1 = 4'hF; tick();
    wr1 = 1'b0; rd1 = 1'b1; tick();
    cs1 = 1'b0; rd1 = 1'b0;
    chk("lat1_early", {31'b0, rvalid1}, 32'd0);
    tick();
    chk("lat1_vld", {31'b0, rvalid1}, 32'd1);
    chk("lat1_data", rdata1, d1);
    tick();
    chk("lat1_end", {31'b0, rvalid1}, 32'd0);
    chk("lat1_hold", rdata1, d1);

    // Freeze for three cycles right after a read accept
    d2 = $urandom;
    cs1 = 1'b1; wr1 = 1'b1; addr1 = 4'd9; wd1 = d2; be1 = 4'hF; tick();
    wr1 = 1'b0; rd1 = 1'b1; tick();
    cs1 = 1'b0; rd1 = 1'b0;
    chk("frz_accept", {31'b0, rvalid1}, 32'd0);
    clken1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_wait", {31'b0, wreq1}, 32'd1);
      chk("frz_novld", {31'b0, rvalid1}, 32'd0);
    end
    clken1 = 1'b1;
    tick();
    chk("frz_vld", {31'b0, rvalid1}, 32'd1);
    chk("frz_data", rdata1, d2);
    tick();
    chk("frz_end", {31'b0, rvalid1}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
